// File: rtl/br_ram_init_pkg.sv
// Shared types and width helpers for the RAM init write mux.
package br_ram_init_pkg;

    typedef enum logic [1:0] {
        UNINIT = 2'd0,
        INIT   = 2'd1,
        READY  = 2'd2
    } state_e;

    // Address width needed to index a RAM of the given depth.
    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Counter width able to hold every value 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/br_ram_init_wr_pipe.sv
// Write-port output pipeline: Stages register stages (0 = combinational pass-through).
// Valid flops reset to 0; addr/data flops only load alongside a valid beat.
module br_ram_init_wr_pipe #(
    parameter int Stages       = 1,
    parameter int Width        = 1,
    parameter int AddressWidth = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [AddressWidth-1:0] in_addr,
    input  logic [Width-1:0]        in_data,
    output logic                    out_valid,
    output logic [AddressWidth-1:0] out_addr,
    output logic [Width-1:0]        out_data
);

    if (Stages == 0) begin : g_comb
        // The pass-through case has no flops, so the clock and reset go unused.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign out_valid = in_valid;
        assign out_addr  = in_addr;
        assign out_data  = in_data;
    end else begin : g_reg
        logic [Stages-1:0]       vld_q;
        logic [AddressWidth-1:0] addr_q [Stages];
        logic [Width-1:0]        data_q [Stages];

        // Shift beats down the pipe; payload flops are enabled only by their valid.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int i = 0; i < Stages; i++) begin
                    addr_q[i] <= '0;
                    data_q[i] <= '0;
                end
            end else begin
                vld_q[0] <= in_valid;
                if (in_valid) begin
                    addr_q[0] <= in_addr;
                    data_q[0] <= in_data;
                end
                for (int i = 1; i < Stages; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1]) begin
                        addr_q[i] <= addr_q[i-1];
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
        end

        assign out_valid = vld_q[Stages-1];
        assign out_addr  = addr_q[Stages-1];
        assign out_data  = data_q[Stages-1];
    end

endmodule

// File: rtl/br_ram_init_write_mux.sv
// Merges initializer writes with user writes onto one RAM write port.
// User traffic is held off until init completes; init progress is tracked
// against the expected 0..Depth-1 address sequence and errors are flagged.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   UNINIT | out of reset, RAM contents undefined, user writes blocked
//   INIT   | initializer busy, counting its writes, user writes blocked
//   READY  | init finished, user writes accepted while init_busy is low
module br_ram_init_write_mux
    import br_ram_init_pkg::*;
#(
    parameter  int Depth        = 2,
    parameter  int Width        = 1,
    parameter  int OutputStages = 1,
    localparam int AddressWidth = addr_width(Depth)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    init_busy,
    input  logic                    init_wr_valid,
    input  logic [AddressWidth-1:0] init_wr_addr,
    input  logic [Width-1:0]        init_wr_data,
    input  logic                    user_wr_valid,
    output logic                    user_wr_ready,
    input  logic [AddressWidth-1:0] user_wr_addr,
    input  logic [Width-1:0]        user_wr_data,
    output logic                    init_done,
    output logic                    init_error,
    output logic                    ram_wr_valid,
    output logic [AddressWidth-1:0] ram_wr_addr,
    output logic [Width-1:0]        ram_wr_data
);

    localparam int CountWidth = count_width(Depth);
    localparam logic [CountWidth-1:0] CountFull = CountWidth'(Depth);

    state_e                  state_q, state_d;
    logic [CountWidth-1:0]   cnt_q, cnt_d, cnt_base;
    logic                    err_q, err_d;
    logic                    done_q;
    logic                    init_entry;
    logic                    s0_valid;
    logic [AddressWidth-1:0] s0_addr;
    logic [Width-1:0]        s0_data;

    // State, init counter, done and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNINIT;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= (state_d == READY);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            UNINIT:  if (init_busy)  state_d = INIT;
            INIT:    if (!init_busy) state_d = READY;
            READY:   if (init_busy)  state_d = INIT;
            default: state_d = UNINIT;
        endcase
    end

    // Init write tracking. The cycle busy first rises counts as the first
    // write slot, so the counter and error are cleared before it is scored.
    always_comb begin
        init_entry = (state_q != INIT) && init_busy;
        cnt_base   = init_entry ? '0 : cnt_q;
        err_d      = init_entry ? 1'b0 : err_q;
        cnt_d      = cnt_base;
        if (init_wr_valid) begin
            if ((state_q == INIT) || init_entry) begin
                if (CountWidth'(init_wr_addr) != cnt_base) err_d = 1'b1;
                if (cnt_base != CountFull) cnt_d = cnt_base + 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        if ((state_q == INIT) && !init_busy && (cnt_d != CountFull)) err_d = 1'b1;
    end

    // Stage-0 arbiter: init writes always win; users only when ready.
    always_comb begin
        user_wr_ready = (state_q == READY) && !init_busy;
        s0_valid      = 1'b0;
        s0_addr       = '0;
        s0_data       = '0;
        if (init_wr_valid) begin
            s0_valid = 1'b1;
            s0_addr  = init_wr_addr;
            s0_data  = init_wr_data;
        end else if (user_wr_valid && user_wr_ready) begin
            s0_valid = 1'b1;
            s0_addr  = user_wr_addr;
            s0_data  = user_wr_data;
        end
    end

    assign init_done  = done_q;
    assign init_error = err_q;

    br_ram_init_wr_pipe #(
        .Stages       (OutputStages),
        .Width        (Width),
        .AddressWidth (AddressWidth)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s0_valid),
        .in_addr   (s0_addr),
        .in_data   (s0_data),
        .out_valid (ram_wr_valid),
        .out_addr  (ram_wr_addr),
        .out_data  (ram_wr_data)
    );

    a_no_x_ctrl: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({init_busy, init_wr_valid}));

    a_user_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (user_wr_valid && !user_wr_ready) |=>
            (user_wr_valid && $stable(user_wr_addr) && $stable(user_wr_data)));

    a_init_addr: assert property (@(posedge clk) disable iff (!rst_n)
        init_wr_valid |-> (32'(init_wr_addr) < Depth));

    a_user_addr: assert property (@(posedge clk) disable iff (!rst_n)
        user_wr_valid |-> (32'(user_wr_addr) < Depth));

endmodule

// File: tb/tb_br_ram_init_write_mux.sv
// Directed bench: three instances (OutputStages 0, 1, 2) share one stimulus.
module tb_br_ram_init_write_mux;
    import br_ram_init_pkg::*;

    localparam int Depth = 4;
    localparam int Width = 8;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_busy = 1'b0;
    logic          init_wr_valid = 1'b0;
    logic [AW-1:0] init_wr_addr = '0;
    logic [7:0]    init_wr_data = '0;
    logic          user_wr_valid = 1'b0;
    logic [AW-1:0] user_wr_addr = '0;
    logic [7:0]    user_wr_data = '0;

    logic          ready [3];
    logic          done  [3];
    logic          err   [3];
    logic          rv    [3];
    logic [AW-1:0] ra    [3];
    logic [7:0]    rd    [3];

    // Expected stage-0 stream, indexed by cycle; instance k sees it k cycles later.
    logic          ev [16];
    logic [AW-1:0] ea [16];
    logic [7:0]    ed [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    br_ram_init_write_mux #(.Depth(Depth), .Width(Width), .OutputStages(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .init_busy(init_busy), .init_wr_valid(init_wr_valid),
        .init_wr_addr(init_wr_addr), .init_wr_data(init_wr_data),
        .user_wr_valid(user_wr_valid), .user_wr_ready(ready[0]),
        .user_wr_addr(user_wr_addr), .user_wr_data(user_wr_data),
        .init_done(done[0]), .init_error(err[0]),
        .ram_wr_valid(rv[0]), .ram_wr_addr(ra[0]), .ram_wr_data(rd[0]));

    br_ram_init_write_mux #(.Depth(Depth), .Width(Width), .OutputStages(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .init_busy(init_busy), .init_wr_valid(init_wr_valid),
        .init_wr_addr(init_wr_addr), .init_wr_data(init_wr_data),
        .user_wr_valid(user_wr_valid), .user_wr_ready(ready[1]),
        .user_wr_addr(user_wr_addr), .user_wr_data(user_wr_data),
        .init_done(done[1]), .init_error(err[1]),
        .ram_wr_valid(rv[1]), .ram_wr_addr(ra[1]), .ram_wr_data(rd[1]));

    br_ram_init_write_mux #(.Depth(Depth), .Width(Width), .OutputStages(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .init_busy(init_busy), .init_wr_valid(init_wr_valid),
        .init_wr_addr(init_wr_addr), .init_wr_data(init_wr_data),
        .user_wr_valid(user_wr_valid), .user_wr_ready(ready[2]),
        .user_wr_addr(user_wr_addr), .user_wr_data(user_wr_data),
        .init_done(done[2]), .init_error(err[2]),
        .ram_wr_valid(rv[2]), .ram_wr_addr(ra[2]), .ram_wr_data(rd[2]));

    task automatic clear_expect();
        for (int i = 0; i < 16; i++) begin
            ev[i] = 1'b0;
            ea[i] = '0;
            ed[i] = '0;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        init_busy = 1'b0; init_wr_valid = 1'b0; init_wr_addr = '0; init_wr_data = '0;
        user_wr_valid = 1'b0; user_wr_addr = '0; user_wr_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rv[k] !== 1'b0 || done[k] !== 1'b0 || err[k] !== 1'b0 || ready[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset os=%0d got v=%b done=%b err=%b rdy=%b exp all 0",
                         k, rv[k], done[k], err[k], ready[k]);
            end
        end
        checks++;
        if (u_dut1.state_q !== UNINIT || u_dut1.cnt_q !== '0) begin
            errors++;
            $display("FAIL reset_state got state=%0d cnt=%0d exp 0/0", u_dut1.state_q, u_dut1.cnt_q);
        end
    endtask

    task automatic test_blocked_before_init();
        @(posedge clk); #1;
        user_wr_valid = 1'b1; user_wr_addr = 2'd2; user_wr_data = 8'h5A;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ready[k] !== 1'b0 || rv[k] !== 1'b0 || done[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL blocked os=%0d cyc=%0d got rdy=%b v=%b done=%b exp 0/0/0",
                             k, c, ready[k], rv[k], done[k]);
                end
            end
            @(posedge clk); #1;
        end
        // Reset withdraws the never-accepted request.
        apply_reset();
    endtask

    task automatic test_init_clean();
        clear_expect();
        for (int i = 0; i < 4; i++) begin ev[i] = 1'b1; ea[i] = AW'(i); ed[i] = 8'hC3; end
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            init_busy = (c < 4); init_wr_valid = (c < 4);
            init_wr_addr = AW'(c); init_wr_data = 8'hC3;
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                int  j;
                logic xv;
                j  = c - k;
                xv = (j >= 0) ? ev[j] : 1'b0;
                checks++;
                if (rv[k] !== xv || (xv && (ra[k] !== ea[j] || rd[k] !== ed[j]))) begin
                    errors++;
                    $display("FAIL init_wr os=%0d cyc=%0d got v=%b a=%0d d=%h exp v=%b",
                             k, c, rv[k], ra[k], rd[k], xv);
                end
                checks++;
                if (done[k] !== (c >= 5) || err[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL init_done os=%0d cyc=%0d got done=%b err=%b exp done=%b err=0",
                             k, c, done[k], err[k], (c >= 5));
                end
            end
        end
    endtask

    task automatic test_user_write();
        clear_expect();
        ev[0] = 1'b1; ea[0] = 2'd1; ed[0] = 8'h77;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            user_wr_valid = (c == 0); user_wr_addr = 2'd1; user_wr_data = 8'h77;
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                int  j;
                logic xv;
                j  = c - k;
                xv = (j >= 0) ? ev[j] : 1'b0;
                checks++;
                if (rv[k] !== xv || (xv && (ra[k] !== ea[j] || rd[k] !== ed[j]))) begin
                    errors++;
                    $display("FAIL user_wr os=%0d cyc=%0d got v=%b a=%0d d=%h exp v=%b a=1 d=77",
                             k, c, rv[k], ra[k], rd[k], xv);
                end
                checks++;
                if (ready[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL user_ready os=%0d cyc=%0d got %b exp 1", k, c, ready[k]);
                end
            end
        end
    endtask

    task automatic test_reinit_hold();
        clear_expect();
        for (int i = 0; i < 4; i++) begin ev[i] = 1'b1; ea[i] = AW'(i); ed[i] = 8'hC3; end
        ev[5] = 1'b1; ea[5] = 2'd3; ed[5] = 8'h11;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            init_busy = (c < 4); init_wr_valid = (c < 4);
            init_wr_addr = AW'(c); init_wr_data = 8'hC3;
            user_wr_valid = (c <= 5); user_wr_addr = 2'd3; user_wr_data = 8'h11;
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                int  j;
                logic xv;
                j  = c - k;
                xv = (j >= 0) ? ev[j] : 1'b0;
                checks++;
                if (rv[k] !== xv || (xv && (ra[k] !== ea[j] || rd[k] !== ed[j]))) begin
                    errors++;
                    $display("FAIL reinit_wr os=%0d cyc=%0d got v=%b a=%0d d=%h exp v=%b",
                             k, c, rv[k], ra[k], rd[k], xv);
                end
                checks++;
                if (ready[k] !== (c >= 5) || done[k] !== (c == 0 || c >= 5) || err[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL reinit_ctl os=%0d cyc=%0d got rdy=%b done=%b err=%b exp rdy=%b done=%b err=0",
                             k, c, ready[k], done[k], err[k], (c >= 5), (c == 0 || c >= 5));
                end
            end
        end
    endtask

    task automatic test_bad_order();
        logic [AW-1:0] seq [4];
        seq[0] = 2'd0; seq[1] = 2'd2; seq[2] = 2'd1; seq[3] = 2'd3;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            init_busy = (c < 4); init_wr_valid = (c < 4);
            init_wr_addr = seq[c % 4]; init_wr_data = 8'hC3;
            @(negedge clk);
            checks++;
            if (err[1] !== (c >= 2)) begin
                errors++;
                $display("FAIL bad_order cyc=%0d got err=%b exp %b", c, err[1], (c >= 2));
            end
        end
        checks++;
        if (done[1] !== 1'b1 || err[0] !== 1'b1 || err[2] !== 1'b1) begin
            errors++;
            $display("FAIL bad_order_end got done=%b err0=%b err2=%b exp 1/1/1", done[1], err[0], err[2]);
        end
    endtask

    task automatic test_short_init();
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            init_busy = (c < 3); init_wr_valid = (c < 3);
            init_wr_addr = AW'(c); init_wr_data = 8'hC3;
            @(negedge clk);
            checks++;
            if (err[1] !== (c == 0 || c >= 4)) begin
                errors++;
                $display("FAIL short_init cyc=%0d got err=%b exp %b", c, err[1], (c == 0 || c >= 4));
            end
        end
    endtask

    task automatic test_stray_init_write();
        // Clean init clears the sticky error, then one init write arrives in READY.
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            init_busy = (c < 4); init_wr_valid = (c < 4) || (c == 7);
            init_wr_addr = (c == 7) ? 2'd2 : AW'(c); init_wr_data = (c == 7) ? 8'hE1 : 8'hC3;
            @(negedge clk);
            checks++;
            if (err[1] !== (c == 0 || c == 8)) begin
                errors++;
                $display("FAIL stray_err cyc=%0d got err=%b exp %b", c, err[1], (c == 0 || c == 8));
            end
            if (c == 7) begin
                checks++;
                if (rv[0] !== 1'b1 || ra[0] !== 2'd2 || rd[0] !== 8'hE1 || ready[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL stray_fwd got v=%b a=%0d d=%h rdy=%b exp v=1 a=2 d=e1 rdy=1",
                             rv[0], ra[0], rd[0], ready[0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_init();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            init_busy = 1'b1; init_wr_valid = 1'b1;
            init_wr_addr = AW'(c); init_wr_data = 8'h3C;
            @(negedge clk);
        end
        checks++;
        if (rv[1] !== 1'b1 || ra[1] !== 2'd0) begin
            errors++;
            $display("FAIL mid_init_pre got v=%b a=%0d exp v=1 a=0", rv[1], ra[1]);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        init_busy = 1'b0; init_wr_valid = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rv[k] !== 1'b0 || done[k] !== 1'b0 || err[k] !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset os=%0d got v=%b done=%b err=%b exp 0/0/0",
                         k, rv[k], done[k], err[k]);
            end
        end
        checks++;
        if (u_dut1.state_q !== UNINIT) begin
            errors++;
            $display("FAIL mid_reset_state got %0d exp 0", u_dut1.state_q);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        user_wr_valid = 1'b1; user_wr_addr = 2'd2; user_wr_data = 8'h99;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ready[k] !== 1'b0 || rv[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL post_reset os=%0d cyc=%0d got rdy=%b v=%b exp 0/0",
                             k, c, ready[k], rv[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_blocked_before_init();
        test_init_clean();
        test_user_write();
        test_reinit_hold();
        test_bad_order();
        test_short_init();
        test_stray_init_write();
        test_reset_mid_init();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
